// File: rtl/fc_layer_sequencer_if.sv
// Memory-read and result port bundle of the sequential fully-connected layer engine.
// master = the engine, slave = the buffers / downstream side.
interface fc_layer_sequencer_if #(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned LAYER_SZ = 10,
    parameter int unsigned NEURONS  = 10
);
    localparam int unsigned WAW = (NEURONS * LAYER_SZ > 1) ? $clog2(NEURONS * LAYER_SZ) : 1;
    localparam int unsigned XAW = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam int unsigned NAW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [WAW-1:0]  w_addr;
    logic [XAW-1:0]  x_addr;
    logic [NAW-1:0]  b_addr;
    logic [SIZE-1:0] w_data;
    logic [SIZE-1:0] x_data;
    logic [SIZE-1:0] b_data;
    logic            out_valid;
    logic            out_ready;
    logic [NAW-1:0]  out_addr;
    logic [SIZE-1:0] out_data;

    modport master (
        input  start, w_data, x_data, b_data, out_ready,
        output busy, done, rd_en, w_addr, x_addr, b_addr, out_valid, out_addr, out_data
    );

    modport slave (
        output start, w_data, x_data, b_data, out_ready,
        input  busy, done, rd_en, w_addr, x_addr, b_addr, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer engine: one shared multiplier/accumulator walks every neuron,
// streaming weights/inputs/biases from 1-cycle-latency memories and emitting one result per neuron.
module fc_layer_sequencer #(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned PRECISION = 11,
    parameter int unsigned LAYER_SZ  = 10,
    parameter int unsigned NEURONS   = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    fc_layer_sequencer_if.master bus
);
    localparam int unsigned WAW  = (NEURONS * LAYER_SZ > 1) ? $clog2(NEURONS * LAYER_SZ) : 1;
    localparam int unsigned XAW  = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam int unsigned NAW  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int unsigned ACCW = 2 * SIZE;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT, S_DONE} state_t;

    state_t          r_state,     w_state_nxt;
    logic [NAW-1:0]  r_n,         w_n_nxt;
    logic [XAW-1:0]  r_k,         w_k_nxt;
    logic [ACCW-1:0] r_acc,       w_acc_nxt;
    logic            r_busy,      w_busy_nxt;
    logic            r_done,      w_done_nxt;
    logic            r_rd_en,     w_rd_en_nxt;
    logic [WAW-1:0]  r_w_addr,    w_w_addr_nxt;
    logic [XAW-1:0]  r_x_addr,    w_x_addr_nxt;
    logic [NAW-1:0]  r_b_addr,    w_b_addr_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [NAW-1:0]  r_out_addr,  w_out_addr_nxt;
    logic [SIZE-1:0] r_out_data,  w_out_data_nxt;
    logic [ACCW-1:0] w_prod;

    assign w_prod = ACCW'(bus.w_data) * ACCW'(bus.x_data);

    // Next-state logic; every output is registered from its *_nxt value so it lines up with r_state.
    always_comb begin
        w_state_nxt     = r_state;
        w_n_nxt         = r_n;
        w_k_nxt         = r_k;
        w_acc_nxt       = r_acc;
        w_rd_en_nxt     = 1'b0;
        w_w_addr_nxt    = r_w_addr;
        w_x_addr_nxt    = r_x_addr;
        w_b_addr_nxt    = r_b_addr;
        w_out_valid_nxt = 1'b0;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;

        unique case (r_state)
            S_IDLE: begin
                w_n_nxt        = '0;
                w_k_nxt        = '0;
                w_acc_nxt      = '0;
                w_w_addr_nxt   = '0;
                w_x_addr_nxt   = '0;
                w_b_addr_nxt   = '0;
                w_out_addr_nxt = '0;
                w_out_data_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_rd_en_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_MAC;
                w_k_nxt     = '0;
                if (LAYER_SZ > 1) begin
                    w_rd_en_nxt  = 1'b1;
                    w_w_addr_nxt = r_w_addr + WAW'(1);
                    w_x_addr_nxt = r_x_addr + XAW'(1);
                end
            end
            S_MAC: begin
                // First product also folds in the bias, aligned to the fractional point.
                if (r_k == '0) begin
                    w_acc_nxt = (ACCW'(bus.b_data) << PRECISION) + w_prod;
                end else begin
                    w_acc_nxt = r_acc + w_prod;
                end
                if (32'(r_k) == LAYER_SZ - 1) begin
                    w_state_nxt     = S_OUT;
                    w_out_valid_nxt = 1'b1;
                    w_out_addr_nxt  = r_n;
                    w_out_data_nxt  = w_acc_nxt[PRECISION+SIZE-1 -: SIZE];
                end else begin
                    w_k_nxt = r_k + XAW'(1);
                    if (32'(r_k) + 32'd2 < LAYER_SZ) begin
                        w_rd_en_nxt  = 1'b1;
                        w_w_addr_nxt = r_w_addr + WAW'(1);
                        w_x_addr_nxt = r_x_addr + XAW'(1);
                    end
                end
            end
            S_OUT: begin
                w_out_valid_nxt = 1'b1;
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (32'(r_n) == NEURONS - 1) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // w_addr still holds the last weight of this neuron, so +1 is the next row.
                        w_state_nxt  = S_LOAD;
                        w_n_nxt      = r_n + NAW'(1);
                        w_rd_en_nxt  = 1'b1;
                        w_w_addr_nxt = r_w_addr + WAW'(1);
                        w_x_addr_nxt = '0;
                        w_b_addr_nxt = r_n + NAW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_w_addr    <= '0;
            r_x_addr    <= '0;
            r_b_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_k         <= w_k_nxt;
            r_acc       <= w_acc_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_x_addr    <= w_x_addr_nxt;
            r_b_addr    <= w_b_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.w_addr    = r_w_addr;
    assign bus.x_addr    = r_x_addr;
    assign bus.b_addr    = r_b_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
endmodule
